// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: ALU op codes, arbiter state encoding and legal-op check shared by alu_share_arbiter
package alu_arb_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  function automatic logic op_legal(input logic [3:0] op);
    return op inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL};
  endfunction
endpackage

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: combinational round-robin grant, scanning upward from ptr and wrapping at NREQ
module alu_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] idx,
  output logic            any
);
  // scan downward so the candidate closest to ptr overwrites the others
  always_comb begin
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (valid[(int'(ptr) + k) % NREQ]) idx = IDXW'((int'(ptr) + k) % NREQ);
  end
  assign any   = |valid;
  assign grant = any ? NREQ'(1) << idx : '0;
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sequencer sharing one external 32-bit ALU among NREQ requesters
// ALU_ARB_ERR_EN: reject op codes outside the legal set with rsp_err instead of issuing them
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_op,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  input  logic [5*NREQ-1:0] req_shamt,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [31:0]       rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [3:0]        alu_op,
  output logic [4:0]        alu_shamt,
  input  logic [31:0]       alu_result,
  input  logic              alu_zero
);
  logic [1:0]      state;
  logic [IDXW-1:0] ptr, g, idx;
  logic [NREQ-1:0] grant;
  logic            any, hs, ack, bad;
  logic [3:0]      op_in;
  alu_rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
    .valid(req_valid),
    .ptr  (ptr),
    .grant(grant),
    .idx  (idx),
    .any  (any)
  );
  assign op_in     = req_op[4*idx +: 4];
  assign req_ready = (state == IDLE) ? grant : '0;
  assign hs        = (state == IDLE) && any;
  assign ack       = (state == RESP) && rsp_ready[g];
  assign rsp_valid = (state == RESP) ? NREQ'(1) << g : '0;
`ifdef ALU_ARB_ERR_EN
  assign bad = !op_legal(op_in);
`else
  assign bad = 1'b0;
`endif
  // alu_* registers only move on an accepted legal op, so the ALU inputs stay quiet otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      g          <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_shamt  <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (hs) begin
        g       <= idx;
        rsp_err <= bad;
        state   <= bad ? RESP : EXEC;
        if (bad) begin
          rsp_result <= '0;
          rsp_zero   <= 1'b0;
        end else begin
          alu_op    <= op_in;
          alu_a     <= req_a[32*idx +: 32];
          alu_b     <= req_b[32*idx +: 32];
          alu_shamt <= req_shamt[5*idx +: 5];
        end
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        state      <= RESP;
      end
      if (ack) begin
        ptr   <= (g == IDXW'(NREQ - 1)) ? '0 : g + IDXW'(1);
        state <= IDLE;
      end
    end
  end
endmodule
